// File: rtl/des_region_scheduler.sv
// Region scheduler: walks a region range, dispatches regions to des_block workers and sums their counters.
// Optional job cycle counter enabled by defining DES_SCHED_CYCLE_COUNT_EN.

module des_region_scheduler #(
  parameter int NUM_BLOCKS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  input  logic [15:0]              region_first,
  input  logic [15:0]              region_last,
  input  logic [NUM_BLOCKS-1:0]    blk_done,
  input  logic [48*NUM_BLOCKS-1:0] blk_counter,
  output logic [NUM_BLOCKS-1:0]    blk_start,
  output logic [NUM_BLOCKS-1:0]    blk_restart,
  output logic [16*NUM_BLOCKS-1:0] blk_region,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [63:0]              total,
  output logic [16:0]              regions_completed,
  output logic [31:0]              job_cycles
);

  localparam int IW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state, state_d;
  logic [NUM_BLOCKS-1:0]   busy_vec, busy_d;
  logic [NUM_BLOCKS-1:0]   pend, pend_d;
  logic [NUM_BLOCKS-1:0]   cand, coll_oh, disp_oh;
  logic [2*NUM_BLOCKS-1:0] cand_dbl;
  logic [16:0]             next_region, next_region_d, next_inc;
  logic [15:0]             last_q, last_d;
  logic [IW-1:0]           rr_last, rr_last_d, rr_next, coll_sel;
  logic [IW:0]             coll_sum;
  logic                    coll_found;
  logic [47:0]             coll_count;
  logic [63:0]             total_d;
  logic [16:0]             completed_d;
  logic                    aborted_d;
  logic                    running;

  // A worker restarted last cycle may still show done, so it is not a candidate again.
  assign cand     = busy_vec & blk_done & ~pend;
  assign cand_dbl = {cand, cand} >> rr_next;
  assign next_inc = next_region + 17'd1;
  assign rr_next  = (rr_last == IW'(NUM_BLOCKS - 1)) ? '0 : rr_last + 1'b1;
  assign running  = (state == S_RUN) || (state == S_DRAIN);
  assign busy     = running;
  assign done     = (state == S_DONE);

  always_comb begin
    coll_found = 1'b0;
    coll_sum   = '0;
    coll_oh    = '0;
    disp_oh    = '0;
    coll_count = '0;
    for (int p = 0; p < NUM_BLOCKS; p++) begin
      if (!coll_found && cand_dbl[p]) begin
        coll_found = 1'b1;
        coll_sum   = {1'b0, rr_next} + (IW+1)'(p);
      end
    end
    if (coll_sum >= (IW+1)'(NUM_BLOCKS)) begin
      coll_sum = coll_sum - (IW+1)'(NUM_BLOCKS);
    end
    for (int j = 0; j < NUM_BLOCKS; j++) begin
      coll_oh[j] = coll_found && (coll_sum == (IW+1)'(j));
      if (coll_oh[j]) begin
        coll_count = blk_counter[48*j +: 48];
      end
      if (disp_oh == '0 && !busy_vec[j]) begin
        disp_oh[j] = 1'b1;
      end
    end
    coll_sel = coll_sum[IW-1:0];
  end

  always_comb begin
    state_d       = state;
    busy_d        = busy_vec & ~pend;
    pend_d        = '0;
    next_region_d = next_region;
    last_d        = last_q;
    rr_last_d     = rr_last;
    total_d       = total;
    completed_d   = regions_completed;
    aborted_d     = aborted;
    blk_start     = '0;
    blk_restart   = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (cmd_start) begin
          total_d       = '0;
          completed_d   = '0;
          aborted_d     = 1'b0;
          next_region_d = {1'b0, region_first};
          last_d        = region_last;
          state_d       = (region_first > region_last) ? S_DONE : S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        if (cmd_abort) begin
          blk_restart = busy_vec;
          busy_d      = '0;
          aborted_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          if (coll_found) begin
            blk_restart = coll_oh;
            pend_d      = coll_oh;
            total_d     = total + {16'd0, coll_count};
            completed_d = regions_completed + 17'd1;
            rr_last_d   = coll_sel;
          end
          if (state == S_RUN && disp_oh != '0) begin
            blk_start     = disp_oh;
            busy_d        = busy_d | disp_oh;
            next_region_d = next_inc;
            if (next_inc > {1'b0, last_q}) begin
              state_d = S_DRAIN;
            end
          end
          if (state == S_DRAIN && busy_vec == '0) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Workers are held cleared for as long as reset is asserted.
    if (rst) begin
      blk_start   = '0;
      blk_restart = '1;
    end
  end

  // Idle workers always hold the region they would receive, so it is valid in the start cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      busy_vec          <= '0;
      pend              <= '0;
      next_region       <= '0;
      last_q            <= '0;
      rr_last           <= IW'(NUM_BLOCKS - 1);
      total             <= '0;
      regions_completed <= '0;
      aborted           <= 1'b0;
      blk_region        <= '0;
    end else begin
      state             <= state_d;
      busy_vec          <= busy_d;
      pend              <= pend_d;
      next_region       <= next_region_d;
      last_q            <= last_d;
      rr_last           <= rr_last_d;
      total             <= total_d;
      regions_completed <= completed_d;
      aborted           <= aborted_d;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (!busy_d[i]) begin
          blk_region[16*i +: 16] <= next_region_d[15:0];
        end
      end
    end
  end

`ifdef DES_SCHED_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      job_cycles <= '0;
    end else if (cmd_start && !running) begin
      job_cycles <= '0;
    end else if (running && job_cycles != 32'hFFFF_FFFF) begin
      job_cycles <= job_cycles + 32'd1;
    end
  end
`else
  assign job_cycles = '0;
`endif

endmodule

// File: tb/tb_des_region_scheduler.sv
// Self-checking bench for des_region_scheduler: table vectors, corner sequences and random jobs vs. a range-sum model.

module tb_des_region_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst, cmd_start, cmd_abort;
  logic [15:0]     region_first, region_last;
  logic [N-1:0]    blk_done;
  logic [48*N-1:0] blk_counter;
  logic [N-1:0]    blk_start, blk_restart;
  logic [16*N-1:0] blk_region;
  logic            busy, done, aborted;
  logic [63:0]     total;
  logic [16:0]     regions_completed;
  logic [31:0]     job_cycles;

  always #5 clk = ~clk;

  des_region_scheduler #(.NUM_BLOCKS(N)) dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .region_first(region_first), .region_last(region_last),
    .blk_done(blk_done), .blk_counter(blk_counter),
    .blk_start(blk_start), .blk_restart(blk_restart), .blk_region(blk_region),
    .busy(busy), .done(done), .aborted(aborted), .total(total),
    .regions_completed(regions_completed), .job_cycles(job_cycles)
  );

  int checks = 0, errors = 0;

  // Worker models: done after lat cycles, counter derived from the region, done lingers one cycle after restart.
  int          lat [N];
  bit          hold_mode;
  logic [47:0] cmul, cadd;
  bit          wactive [N];
  bit          wlinger [N];
  int          wtimer [N];
  int          start_busy_err = 0;

  function automatic logic [47:0] cntfun(input logic [15:0] r);
    return 48'(r) * cmul + cadd;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        wactive[i] <= 1'b0; wlinger[i] <= 1'b0; wtimer[i] <= 0;
        blk_done[i] <= 1'b0; blk_counter[48*i +: 48] <= '0;
      end else if (blk_restart[i]) begin
        wactive[i] <= 1'b0; wtimer[i] <= 0;
        if (blk_done[i] && !wlinger[i]) wlinger[i] <= 1'b1;
        else begin blk_done[i] <= 1'b0; wlinger[i] <= 1'b0; end
      end else if (wlinger[i]) begin
        blk_done[i] <= 1'b0; wlinger[i] <= 1'b0;
      end else if (blk_start[i]) begin
        if (wactive[i] || blk_done[i]) start_busy_err++;
        wactive[i] <= 1'b1; wtimer[i] <= 1;
        blk_counter[48*i +: 48] <= cntfun(blk_region[16*i +: 16]);
      end else if (wactive[i] && !blk_done[i]) begin
        if (wtimer[i] >= lat[i] - 1) begin
          if (!hold_mode) blk_done[i] <= 1'b1;
        end else wtimer[i] <= wtimer[i] + 1;
      end
    end
  end

  // Monitor on the falling edge: logs starts and restarts with their cycle numbers.
  int cyc = 0, n_starts = 0, n_restarts = 0, busy_cycles = 0;
  int start_wkr[$], start_reg[$], start_cyc[$], rst_wkr[$], rst_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (busy) busy_cycles++;
      for (int i = 0; i < N; i++) begin
        if (blk_start[i]) begin
          n_starts++; start_wkr.push_back(i);
          start_reg.push_back(int'(blk_region[16*i +: 16])); start_cyc.push_back(cyc);
        end
        if (blk_restart[i]) begin
          n_restarts++; rst_wkr.push_back(i); rst_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [15:0] first;
    logic [15:0] last;
    int          lat;
    logic [47:0] cmul;
    logic [47:0] cadd;
    logic [63:0] exp_total;
    int          exp_rc;
  } vec_t;

  vec_t vecs [8];
  int   job_t0;
  bit   seen [int];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic doReset();
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic setWorkers(input int l, input logic [47:0] m, input logic [47:0] a);
    for (int i = 0; i < N; i++) lat[i] = l;
    cmul = m; cadd = a;
  endtask

  task automatic applyStimulus(input logic [15:0] f, input logic [15:0] l, input int tmo,
                               output int waited);
    bit ok = 1'b0;
    region_first = f; region_last = l; cmd_start = 1'b1; job_t0 = cyc;
    tick();
    waited = 1;
    while (waited <= tmo) begin
      cmd_start = (waited == 3) && busy;
      if (hold_mode && waited == 20) hold_mode = 1'b0;
      if (done) begin ok = 1'b1; break; end
      tick();
      waited++;
    end
    cmd_start = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL job_timeout: got no done within %0d cycles, required done", tmo);
      doReset();
    end
  endtask

  task automatic verifyJob(input string tag, input logic [15:0] f, input logic [15:0] l,
                           input logic [63:0] exp_total, input int exp_rc,
                           input int s0, input int r0, input int e0);
    int bad = 0;
    seen.delete();
    for (int k = s0; k < start_reg.size(); k++) begin
      if (start_reg[k] < int'(f) || start_reg[k] > int'(l) || seen.exists(start_reg[k])) bad++;
      seen[start_reg[k]] = 1'b1;
    end
    checkOutput({tag, " done"}, 64'(done), 64'd1);
    checkOutput({tag, " total"}, total, exp_total);
    checkOutput({tag, " regions_completed"}, 64'(regions_completed), 64'(exp_rc));
    checkOutput({tag, " start_count"}, 64'(n_starts - s0), 64'(exp_rc));
    checkOutput({tag, " restart_count"}, 64'(n_restarts - r0), 64'(exp_rc));
    checkOutput({tag, " start_while_busy"}, 64'(start_busy_err - e0), 64'd0);
    checkOutput({tag, " dispatch_set_bad"}, 64'(bad), 64'd0);
    checkOutput({tag, " aborted"}, 64'(aborted), 64'd0);
  endtask

  initial begin
    int s0, r0, e0, b0, w, exp_rc, len;
    logic [15:0] f, l;
    logic [63:0] exp_total, rnd;
    logic [N-1:0] exp_rst;

    vecs[0] = '{16'h0000, 16'h0003, 10, 48'd1, 48'd5, 64'd26, 4};
    vecs[1] = '{16'h0000, 16'h0009, 10, 48'd1, 48'd5, 64'd95, 10};
    vecs[2] = '{16'hFFFE, 16'hFFFF, 4, 48'd1, 48'd5, 64'd131079, 2};
    vecs[3] = '{16'h0005, 16'h0004, 10, 48'd1, 48'd5, 64'd0, 0};
    vecs[4] = '{16'h0000, 16'h000F, 3, 48'd1, 48'd5, 64'd200, 16};
    vecs[5] = '{16'h0064, 16'h0064, 2, 48'd2, 48'd0, 64'd200, 1};
    vecs[6] = '{16'h0007, 16'h000C, 5, 48'h1_0000_0000, 48'h0000_0000_FFFF, 64'd244813529082, 6};
    vecs[7] = '{16'h0000, 16'h0001, 3, 48'd0, 48'hFFFF_FFFF_FFFF, 64'd562949953421310, 2};

    hold_mode = 1'b0; region_first = '0; region_last = '0;
    setWorkers(10, 48'd1, 48'd5);

    // Reset state
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0;
    tick(); tick(); #1;
    checkOutput("reset blk_restart", 64'(blk_restart), 64'hF);
    checkOutput("reset blk_start", 64'(blk_start), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset aborted", 64'(aborted), 64'd0);
    checkOutput("reset total", total, 64'd0);
    checkOutput("reset regions_completed", 64'(regions_completed), 64'd0);
    checkOutput("reset blk_region", blk_region, 64'd0);
    checkOutput("reset job_cycles", 64'(job_cycles), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven jobs
    for (int v = 0; v < 8; v++) begin
      setWorkers(vecs[v].lat, vecs[v].cmul, vecs[v].cadd);
      s0 = n_starts; r0 = n_restarts; e0 = start_busy_err;
      applyStimulus(vecs[v].first, vecs[v].last, vecs[v].exp_rc * 20 + 60, w);
      verifyJob($sformatf("vec%0d", v), vecs[v].first, vecs[v].last,
                vecs[v].exp_total, vecs[v].exp_rc, s0, r0, e0);
      if (vecs[v].exp_rc == 0) checkOutput($sformatf("vec%0d empty_latency", v), 64'(w), 64'd1);
      else if (start_cyc.size() > s0)
        checkOutput($sformatf("vec%0d first_start_latency", v), 64'(start_cyc[s0] - job_t0), 64'd1);
      if (v == 0 && start_wkr.size() >= s0 + 4) begin
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("basic worker_order%0d", k), 64'(start_wkr[s0+k]), 64'(k));
          checkOutput($sformatf("basic region_order%0d", k), 64'(start_reg[s0+k]), 64'(k));
        end
      end
    end

    // Simultaneous done on all workers
    setWorkers(3, 48'd1, 48'd5);
    hold_mode = 1'b1;
    s0 = n_starts; r0 = n_restarts; e0 = start_busy_err;
    applyStimulus(16'd0, 16'd3, 200, w);
    verifyJob("simul", 16'd0, 16'd3, 64'd26, 4, s0, r0, e0);
    if (rst_cyc.size() >= r0 + 4) begin
      for (int k = 1; k < 4; k++) begin
        checkOutput($sformatf("simul restart_cycle%0d", k), 64'(rst_cyc[r0+k] - rst_cyc[r0]), 64'(k));
        checkOutput($sformatf("simul rr_order%0d", k), 64'(rst_wkr[r0+k]), 64'((rst_wkr[r0] + k) % N));
      end
    end

    // Cycle count on a single-region job
    setWorkers(10, 48'd1, 48'd5);
    b0 = busy_cycles; s0 = n_starts; r0 = n_restarts; e0 = start_busy_err;
    applyStimulus(16'd10, 16'd10, 100, w);
    verifyJob("cycles", 16'd10, 16'd10, 64'd15, 1, s0, r0, e0);
    checkOutput("cycles busy_span", 64'(busy_cycles - b0), 64'd13);
`ifdef DES_SCHED_CYCLE_COUNT_EN
    checkOutput("cycles job_cycles", 64'(job_cycles), 64'(busy_cycles - b0));
`else
    checkOutput("cycles job_cycles", 64'(job_cycles), 64'd0);
`endif

    // Abort after two collections
    lat[0] = 6; lat[1] = 8; lat[2] = 40; lat[3] = 40; cmul = 48'd1; cadd = 48'd5;
    region_first = 16'd0; region_last = 16'd9; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    w = 0;
    while (regions_completed != 17'd2 && w < 200) begin tick(); w++; end
    checkOutput("abort reached_two", 64'(regions_completed), 64'd2);
    tick(); tick();
    for (int i = 0; i < N; i++) exp_rst[i] = wactive[i] | blk_done[i];
    s0 = n_starts;
    cmd_abort = 1'b1; #1;
    checkOutput("abort restart_vector", 64'(blk_restart), 64'(exp_rst));
    tick();
    cmd_abort = 1'b0;
    checkOutput("abort aborted", 64'(aborted), 64'd1);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort done", 64'(done), 64'd0);
    checkOutput("abort regions_completed", 64'(regions_completed), 64'd2);
    checkOutput("abort total", total, 64'd11);
    repeat (5) tick();
    checkOutput("abort no_dispatch", 64'(n_starts - s0), 64'd0);
    setWorkers(4, 48'd1, 48'd5);
    s0 = n_starts; r0 = n_restarts; e0 = start_busy_err;
    applyStimulus(16'd0, 16'd0, 100, w);
    verifyJob("after_abort", 16'd0, 16'd0, 64'd5, 1, s0, r0, e0);

    // Reset in the middle of a job
    region_first = 16'd0; region_last = 16'd9; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (5) tick();
    rst = 1'b1; #1;
    checkOutput("midreset blk_restart", 64'(blk_restart), 64'hF);
    checkOutput("midreset blk_start", 64'(blk_start), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset total", total, 64'd0);
    checkOutput("midreset blk_region", blk_region, 64'd0);

    // Randomized jobs against the range-sum model
    for (int j = 0; j < 12; j++) begin
      if ($urandom_range(0, 3) == 0) f = 16'hFFFF - 16'($urandom_range(0, 6));
      else f = 16'($urandom_range(0, 65535));
      len = $urandom_range(0, 13);
      if ($urandom_range(0, 7) == 0 && f != 16'd0) l = f - 16'd1;
      else l = (int'(f) + len > 65535) ? 16'hFFFF : f + 16'(len);
      for (int i = 0; i < N; i++) lat[i] = $urandom_range(2, 9);
      rnd = {$urandom, $urandom}; cmul = rnd[47:0];
      rnd = {$urandom, $urandom}; cadd = rnd[47:0];
      exp_rc = 0; exp_total = '0;
      for (int r = int'(f); r <= int'(l); r++) begin
        exp_rc++;
        exp_total = exp_total + {16'd0, cntfun(16'(r))};
      end
      s0 = n_starts; r0 = n_restarts; e0 = start_busy_err;
      applyStimulus(f, l, exp_rc * 20 + 60, w);
      verifyJob($sformatf("rand%0d", j), f, l, exp_total, exp_rc, s0, r0, e0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
